// File: rtl/spi_slave_regfile.sv
// ============================================================================
// Module   : spi_slave_regfile
// Brief    : Oversampled SPI mode-0 responder with a small register file that
//            emulates the JT201D register interface (R/W + addr + data frames).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_regfile #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 20,
    parameter int                REG_AW    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              i_clk_sys,
    input  logic              i_rst,
    input  logic              i_SCLK,
    input  logic              i_MOSI,
    input  logic              i_SEN,
    output logic              o_MISO,
    output logic              o_wr_strobe,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_frame_err,
    output logic              o_addr_err
);

    localparam int DEPTH = 2 ** REG_AW;
    localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [1:0]        sclk_sync, mosi_sync, sen_sync;
    logic              sclk_q, sen_q;
    logic [2:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              rw;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] regs [DEPTH];

    logic              sclk_rise, sclk_fall, sen_rise, sen_fall, mosi;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;
    logic              addr_next_mapped, addr_mapped;

    assign sclk_rise        = sclk_sync[1] & ~sclk_q;
    assign sclk_fall        = ~sclk_sync[1] & sclk_q;
    assign sen_rise         = sen_sync[1] & ~sen_q;
    assign sen_fall         = ~sen_sync[1] & sen_q;
    assign mosi             = mosi_sync[1];
    assign addr_next        = {addr_sh[ADDR_W-2:0], mosi};
    assign wdata_next       = {data_sh[DATA_W-2:0], mosi};
    assign addr_next_mapped = (addr_next[ADDR_W-1:REG_AW] == '0);
    assign addr_mapped      = (addr_sh[ADDR_W-1:REG_AW] == '0);

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            // SEN flops reset low so an enable still held low after reset
            // cannot masquerade as a fresh falling edge.
            sclk_sync   <= '0;
            mosi_sync   <= '0;
            sen_sync    <= '0;
            sclk_q      <= 1'b0;
            sen_q       <= 1'b0;
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rw          <= 1'b0;
            addr_sh     <= '0;
            data_sh     <= '0;
            o_MISO      <= 1'b1;
            o_wr_strobe <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_frame_err <= 1'b0;
            o_addr_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            sclk_sync   <= {sclk_sync[0], i_SCLK};
            mosi_sync   <= {mosi_sync[0], i_MOSI};
            sen_sync    <= {sen_sync[0], i_SEN};
            sclk_q      <= sclk_sync[1];
            sen_q       <= sen_sync[1];
            o_wr_strobe <= 1'b0;
            o_frame_err <= 1'b0;
            o_addr_err  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    o_MISO <= 1'b1;
                    if (sen_fall) begin
                        bit_cnt <= '0;
                        state   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sen_rise) begin
                        o_frame_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (sclk_rise) begin
                        rw      <= mosi;
                        bit_cnt <= '0;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (sen_rise) begin
                        o_frame_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (sclk_rise) begin
                        addr_sh <= addr_next;
                        if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                            if (rw) begin
                                data_sh    <= addr_next_mapped ? regs[addr_next[REG_AW-1:0]] : '0;
                                o_addr_err <= ~addr_next_mapped;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    // Final rise wins over a coincident SEN rise, so the write commits.
                    if (sclk_rise && bit_cnt == CNT_W'(DATA_W - 1)) begin
                        o_MISO <= 1'b1;
                        state  <= sen_rise ? ST_IDLE : ST_DONE;
                        if (!rw) begin
                            if (addr_mapped) begin
                                regs[addr_sh[REG_AW-1:0]] <= wdata_next;
                                o_wr_strobe <= 1'b1;
                                o_wr_addr   <= addr_sh;
                                o_wr_data   <= wdata_next;
                            end else begin
                                o_addr_err <= 1'b1;
                            end
                        end
                    end else if (sen_rise) begin
                        o_frame_err <= 1'b1;
                        o_MISO      <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (!rw) begin
                            data_sh <= wdata_next;
                        end
                    end else if (sclk_fall && rw) begin
                        o_MISO  <= data_sh[DATA_W-1];
                        data_sh <= {data_sh[DATA_W-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    o_MISO <= 1'b1;
                    if (sen_rise) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    o_MISO <= 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_regfile.sv
// ============================================================================
// Module   : tb_spi_slave_regfile
// Brief    : Scoreboard bench driving SPI frames into spi_slave_regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_regfile;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst, sclk, mosi, sen;
    logic        miso, wr_strobe, frame_err, addr_err;
    logic [11:0] wr_addr;
    logic [19:0] wr_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_strobe = 0, cnt_ferr = 0, cnt_aerr = 0;

    logic [31:0] wr_q [$];
    logic [19:0] rd_q [$];
    logic [19:0] mdl  [16];

    always #5 clk = ~clk;

    spi_slave_regfile dut (
        .i_clk_sys   (clk),
        .i_rst       (rst),
        .i_SCLK      (sclk),
        .i_MOSI      (mosi),
        .i_SEN       (sen),
        .o_MISO      (miso),
        .o_wr_strobe (wr_strobe),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_frame_err (frame_err),
        .o_addr_err  (addr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Write-commit monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe) begin
                cnt_strobe++;
                check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    logic [31:0] e;
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[31:20]));
                    check("wr_data", 32'(wr_data), 32'(e[19:0]));
                end
            end
            if (frame_err) cnt_ferr++;
            if (addr_err)  cnt_aerr++;
        end
    end

    task automatic frame(input string tag, input bit rw, input logic [11:0] addr,
                         input logic [19:0] data, input int nclk, input bit mid_rst,
                         input int d_str, input int d_ferr, input int d_aerr);
        logic [32:0] vec;
        logic [39:0] mi;
        logic [19:0] rdata, e;
        int s0, f0, a0;
        bit mapped, extra_ok;
        vec    = {rw, addr, data};
        mi     = '0;
        mapped = (addr[11:4] == 8'h00);
        s0 = cnt_strobe; f0 = cnt_ferr; a0 = cnt_aerr;
        if (nclk >= 33 && !mid_rst) begin
            if (rw) rd_q.push_back(mapped ? mdl[addr[3:0]] : 20'h0);
            else if (mapped) begin
                wr_q.push_back({addr, data});
                mdl[addr[3:0]] = data;
            end
        end
        sen = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            mosi = (i < 33) ? vec[32-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            mi[i] = miso;
            sclk  = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk  = 1'b0;
        end
        if (mid_rst) begin
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 16; k++) mdl[k] = 20'h0;
        end
        repeat (HALF) @(negedge clk);
        sen = 1'b1;
        repeat (10) @(negedge clk);
        if (rw && nclk >= 33) begin
            for (int k = 0; k < 20; k++) rdata[19-k] = mi[13+k];
            e = rd_q.pop_front();
            check({tag, "_rdata"}, 32'(rdata), 32'(e));
            check({tag, "_miso_hdr"}, 32'(mi[12:0]), 32'h1FFF);
            if (nclk > 33) begin
                extra_ok = 1'b1;
                for (int k = 33; k < nclk; k++) extra_ok &= mi[k];
                check({tag, "_miso_extra"}, 32'(extra_ok), 32'd1);
            end
        end
        check({tag, "_strobes"},  32'(cnt_strobe - s0), 32'(d_str));
        check({tag, "_frame_err"}, 32'(cnt_ferr - f0),  32'(d_ferr));
        check({tag, "_addr_err"},  32'(cnt_aerr - a0),  32'(d_aerr));
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mdl[k] = 20'h0;
        rst = 1'b1; sen = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_miso",      32'(miso),      32'd1);
        check("rst_strobe",    32'(wr_strobe), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_addr_err",  32'(addr_err),  32'd0);
        check("rst_wr_addr",   32'(wr_addr),   32'd0);
        check("rst_wr_data",   32'(wr_data),   32'd0);
        repeat (5) @(negedge clk);

        frame("rd005",    1'b1, 12'h005, 20'h0,     33, 1'b0, 0, 0, 0);
        frame("wr00D",    1'b0, 12'h00D, 20'h1AAFF, 33, 1'b0, 1, 0, 0);
        frame("rd00D",    1'b1, 12'h00D, 20'h0,     33, 1'b0, 0, 0, 0);
        frame("wr3CD",    1'b0, 12'h3CD, 20'hABCDE, 33, 1'b0, 0, 0, 1);
        frame("rd00D_b",  1'b1, 12'h00D, 20'h0,     33, 1'b0, 0, 0, 0);
        frame("rd3CD",    1'b1, 12'h3CD, 20'h0,     33, 1'b0, 0, 0, 1);
        frame("abort",    1'b0, 12'h001, 20'h12345, 20, 1'b0, 0, 1, 0);
        frame("rd001",    1'b1, 12'h001, 20'h0,     33, 1'b0, 0, 0, 0);
        frame("wr001",    1'b0, 12'h001, 20'h55555, 33, 1'b0, 1, 0, 0);
        frame("rd001_b",  1'b1, 12'h001, 20'h0,     33, 1'b0, 0, 0, 0);
        frame("rd00D_40", 1'b1, 12'h00D, 20'h0,     40, 1'b0, 0, 0, 0);
        frame("midrst",   1'b0, 12'h002, 20'h77777, 15, 1'b1, 0, 0, 0);
        frame("rd00D_rv", 1'b1, 12'h00D, 20'h0,     33, 1'b0, 0, 0, 0);
        frame("wr00D_2",  1'b0, 12'h00D, 20'h0F0F0, 33, 1'b0, 1, 0, 0);
        frame("rd00D_2",  1'b1, 12'h00D, 20'h0,     33, 1'b0, 0, 0, 0);

        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- Synthesizable SPI responder that emulates the JT201D register interface. It is the far end of the link that the UART-to-SPI command bridge drives.
- Receives frames on o_SCLK/o_MOSI/o_SEN from the master, updates an internal register file on writes, and returns register contents on MISO for reads.
- Used as a loopback target in the top-level bench and on-board in place of the chip for bring-up.
- All SPI inputs are oversampled in the single system clock domain.

Parameters:
- ADDR_W, 12: address field width in bits.
- DATA_W, 20: data field width in bits.
- REG_AW, 4: implemented address bits. Depth is 2^REG_AW; addresses with any bit set above REG_AW are unmapped.
- RESET_VAL, 20'h00000: reset value of every register.

Ports:
- i_clk_sys, input, 1: system clock; the only clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_SCLK, input, 1: SPI clock from master, asynchronous.
- i_MOSI, input, 1: SPI data from master, asynchronous.
- i_SEN, input, 1: SPI enable, active low, asynchronous.
- o_MISO, output, 1: SPI data to master.
- o_wr_strobe, output, 1: one-cycle pulse when a mapped register is written.
- o_wr_addr, output, ADDR_W: address of the last accepted write.
- o_wr_data, output, DATA_W: data of the last accepted write.
- o_frame_err, output, 1: one-cycle pulse on an aborted frame.
- o_addr_err, output, 1: one-cycle pulse on an access to an unmapped address.

Behaviour:
- Input synchronization
  - i_SCLK, i_MOSI, i_SEN each pass through a 2-flop synchronizer, then an edge-detect register.
  - Required SCLK high and low times: at least 4 i_clk_sys cycles each.
- SPI mode 0
  - MOSI is sampled on the detected SCLK rise.
  - MISO is updated on the detected SCLK fall.
  - MSB first.
- Frame format: 1 + ADDR_W + DATA_W = 33 bits.
  - Bit 0 is R/W: 1 = read, 0 = write.
  - Next ADDR_W bits are the address.
  - Next DATA_W bits are the data. On a write the master drives them; on a read the slave drives them.
- Reset values
  - o_MISO = 1.
  - o_wr_strobe, o_frame_err and o_addr_err = 0.
  - o_wr_addr = 0 and o_wr_data = 0.
  - All registers = RESET_VAL.
  - FSM in IDLE and bit counter at 0.
  - A reset mid-frame discards the frame: no write and no error pulse. Resumption: the FSM re-enters CMD only on the next SEN falling edge.
- FSM states
  - IDLE: o_MISO = 1. On SEN falling edge, clear the bit counter and go to CMD.
  - CMD: on an SCLK rise, latch R/W and go to ADDR.
  - ADDR: shift in ADDR_W bits. On the last address rise, decode the address.
    - On read, load the shift register with the register value, or 0 if unmapped, and go to DATA.
    - On write, go to DATA.
  - DATA
    - Read: on each SCLK fall, o_MISO presents the next data bit, MSB first. The first fall after the last address bit presents bit DATA_W-1.
    - Write: shift in DATA_W bits on rises.
    - On the final data rise, go to DONE.
    - Write commit happens one i_clk_sys cycle after the final rise detection:
      - mapped address: register updated; o_wr_strobe pulses; o_wr_addr and o_wr_data update.
      - unmapped address: no register change; o_addr_err pulses.
    - Unmapped read: o_addr_err pulses at the address decode.
  - DONE: further SCLK edges are ignored and o_MISO = 1. On SEN rising edge, go to IDLE.
- Abort: SEN rises in CMD, ADDR or DATA before the final bit.
  - One-cycle o_frame_err pulse, no write, go to IDLE.
- SEN fall while in DONE or another frame: treated as a new frame only after the return to IDLE. SEN must be high for at least 1 synchronized sample.
- Simultaneous SEN rise and final data rise detected in the same cycle: the write commits and there is no frame_err.
- A read of a register in the same frame as its write is impossible. A back-to-back read returns the new value.
- o_MISO is not tristated; it is driven 1 whenever no read data is being shifted.

Test Plan:
- Reset: assert i_rst for 3 cycles, with SEN held high -> o_MISO = 1, all pulses 0, o_wr_addr = 0, o_wr_data = 0; a read of addr 0x005 then returns 0x00000.
- Write 0x1AAFF to addr 0x00D, then read addr 0x00D -> o_wr_strobe pulses once with o_wr_addr = 0x00D and o_wr_data = 0x1AAFF; the read shifts out 0x1AAFF MSB first on MISO.
- Write 0xABCDE to unmapped addr 0x3CD -> o_addr_err pulses, no o_wr_strobe; a read of 0x00D still returns 0x1AAFF; a read of 0x3CD returns 0x00000 with o_addr_err.
- SEN raised after 20 of 33 bits of a write of 0x12345 to 0x001 -> o_frame_err pulses once; a read of 0x001 returns 0x00000; the next full frame works normally.
- 40 SCLK cycles in one SEN window on a read of 0x00D -> bits 1..33 are correct; the 7 extra falls leave o_MISO = 1; there is no error pulse.
- i_rst asserted mid-write at bit 15 -> no o_wr_strobe; registers are back at RESET_VAL; the next frame after a fresh SEN fall is decoded correctly.
